// File: rtl/ifu_fetch.sv
// ifu_fetch: single-outstanding instruction fetch stage between the PC register and decode.
// Issues one imem request per pc, holds the result for the IDU and strobes pc_wen on a clean accept.
module ifu_fetch #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc,
    output logic            pc_wen,
    input  logic            flush,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            imem_rsp_err,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] inst_pc,
    output logic [1:0]      inst_fault
);
    localparam int unsigned CW = $clog2(MAX_WAIT + 1);

    localparam logic [1:0] F_NONE     = 2'b00;
    localparam logic [1:0] F_MISALIGN = 2'b01;
    localparam logic [1:0] F_BUS      = 2'b10;
    localparam logic [1:0] F_TIMEOUT  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_HOLD  = 3'd3,
        S_DRAIN = 3'd4,
        S_PARK  = 3'd5
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [CW-1:0]   r_wait_cnt;
    logic [31:0]     r_inst;
    logic [XLEN-1:0] r_inst_pc;
    logic [1:0]      r_fault;
    logic            w_aligned;
    logic            w_timeout;

    assign w_aligned = (pc[1:0] == 2'b00);
    // Shared by WAIT and DRAIN: the counter restarts on entry to either.
    assign w_timeout = (r_wait_cnt == CW'(MAX_WAIT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: w_next = S_REQ;
            S_REQ: begin
                if (!flush) begin
                    if (!w_aligned) begin
                        w_next = S_HOLD;
                    end else if (imem_req_ready) begin
                        w_next = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    w_next = flush ? S_REQ : S_HOLD;
                end else if (flush) begin
                    w_next = S_DRAIN;
                end else if (w_timeout) begin
                    w_next = S_HOLD;
                end
            end
            S_DRAIN: begin
                if (imem_rsp_valid || w_timeout) begin
                    w_next = S_REQ;
                end
            end
            S_HOLD: begin
                if (flush) begin
                    w_next = S_REQ;
                end else if (inst_ready) begin
                    w_next = (r_fault == F_NONE) ? S_REQ : S_PARK;
                end
            end
            S_PARK: begin
                if (flush) begin
                    w_next = S_REQ;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        imem_req_valid = 1'b0;
        imem_req_addr  = '0;
        inst_valid     = 1'b0;
        pc_wen         = 1'b0;
        case (r_state)
            S_REQ: begin
                imem_req_valid = ~flush & w_aligned;
                imem_req_addr  = pc;
            end
            S_HOLD: begin
                inst_valid = 1'b1;
                pc_wen     = inst_ready & ~flush & (r_fault == F_NONE);
            end
            default: ;
        endcase
    end

    // Captured instruction, its pc and fault, plus the response wait counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inst     <= '0;
            r_inst_pc  <= '0;
            r_fault    <= F_NONE;
            r_wait_cnt <= '0;
        end else begin
            case (r_state)
                S_REQ: begin
                    if (!flush) begin
                        if (!w_aligned) begin
                            r_inst    <= '0;
                            r_inst_pc <= pc;
                            r_fault   <= F_MISALIGN;
                        end else if (imem_req_ready) begin
                            r_inst_pc  <= pc;
                            r_wait_cnt <= '0;
                        end
                    end
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        if (!flush) begin
                            r_inst  <= imem_rsp_err ? 32'd0 : imem_rsp_data;
                            r_fault <= imem_rsp_err ? F_BUS : F_NONE;
                        end
                    end else if (flush) begin
                        r_wait_cnt <= '0;
                    end else if (w_timeout) begin
                        r_inst  <= '0;
                        r_fault <= F_TIMEOUT;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + CW'(1);
                    end
                end
                S_DRAIN: begin
                    if (!imem_rsp_valid && !w_timeout) begin
                        r_wait_cnt <= r_wait_cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign inst       = r_inst;
    assign inst_pc    = r_inst_pc;
    assign inst_fault = r_fault;

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: table-driven single fetches, directed corner sequences, then random
// traffic against a transaction-level model of the fetch stage, PC register and memory.
module tb_ifu_fetch;
    localparam int MW = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc = 32'h8000_0000;
    logic        pc_wen;
    logic        flush = 1'b0;
    logic        req_valid;
    logic        req_ready = 1'b0;
    logic [31:0] req_addr;
    logic        rsp_valid = 1'b0;
    logic [31:0] rsp_data = 32'd0;
    logic        rsp_err = 1'b0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [1:0]  inst_fault;

    int n_checks = 0;
    int n_err    = 0;
    int n_good   = 0;

    ifu_fetch #(.XLEN(32), .MAX_WAIT(MW)) dut (
        .clk(clk), .rst(rst), .pc(pc), .pc_wen(pc_wen), .flush(flush),
        .imem_req_valid(req_valid), .imem_req_ready(req_ready), .imem_req_addr(req_addr),
        .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data), .imem_rsp_err(rsp_err),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
        .inst_pc(inst_pc), .inst_fault(inst_fault)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    typedef struct {
        logic [31:0] a;
        int          d;
        logic        e;
        logic [31:0] data;
        logic [31:0] x_inst;
        logic [1:0]  x_fault;
        logic        x_wen;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic chk_zero(input string pfx);
        chk({pfx, "_req_valid"},  32'(req_valid), 0);
        chk({pfx, "_req_addr"},   req_addr, 0);
        chk({pfx, "_inst_valid"}, 32'(inst_valid), 0);
        chk({pfx, "_inst"},       inst, 0);
        chk({pfx, "_inst_pc"},    inst_pc, 0);
        chk({pfx, "_fault"},      32'(inst_fault), 0);
        chk({pfx, "_pc_wen"},     32'(pc_wen), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1; flush = 1'b0; req_ready = 1'b0; rsp_valid = 1'b0;
        rsp_data = 32'd0; rsp_err = 1'b0; inst_ready = 1'b0; pc = 32'h8000_0000;
        @(posedge clk); #1;
        chk_zero("rst");
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("idle_req_valid",  32'(req_valid), 0);
        chk("idle_inst_valid", 32'(inst_valid), 0);
    endtask

    // One complete fetch starting in REQ; leaves the DUT so the next cycle is REQ again.
    task automatic fetch_one(input vec_t v);
        @(negedge clk);
        flush = 1'b0; pc = v.a; req_ready = 1'b1; inst_ready = 1'b0; rsp_valid = 1'b0;
        #1;
        chk("issue_req_valid", 32'(req_valid), 32'(v.a[1:0] == 2'b00));
        if (v.a[1:0] == 2'b00) begin
            chk("issue_req_addr", req_addr, v.a);
            for (int k = 0; k < MW; k++) begin
                @(negedge clk);
                req_ready = 1'b0;
                rsp_valid = (k == v.d);
                rsp_data  = v.data;
                rsp_err   = v.e;
                #1;
                chk("wait_req_valid",  32'(req_valid), 0);
                chk("wait_inst_valid", 32'(inst_valid), 0);
                if (k == v.d) break;
            end
        end
        @(negedge clk);
        rsp_valid = 1'b0; req_ready = 1'b0;
        #1;
        chk("hold_inst_valid", 32'(inst_valid), 1);
        chk("hold_inst",       inst, v.x_inst);
        chk("hold_inst_pc",    inst_pc, v.a);
        chk("hold_fault",      32'(inst_fault), 32'(v.x_fault));
        chk("hold_pc_wen_idle", 32'(pc_wen), 0);
        inst_ready = 1'b1;
        #1;
        chk("accept_pc_wen", 32'(pc_wen), 32'(v.x_wen));
        @(negedge clk);
        inst_ready = 1'b0;
        #1;
        chk("after_inst_valid", 32'(inst_valid), 0);
        chk("after_pc_wen",     32'(pc_wen), 0);
        if (v.x_fault != 2'b00) begin
            chk("park_req_valid", 32'(req_valid), 0);
            @(negedge clk);
            flush = 1'b1; pc = 32'h8000_0000;
            #1;
            chk("park_flush_pc_wen",    32'(pc_wen), 0);
            chk("park_flush_req_valid", 32'(req_valid), 0);
        end
    endtask

    // Reference model state for the random phase
    logic        m_pend, m_drain, m_show, m_park;
    int          m_cnt, m_dcnt;
    logic [31:0] m_pc, m_acc, x_inst, x_ipc;
    logic [1:0]  x_fault;
    logic        mem_due, mem_err;
    int          mem_cnt;
    logic [31:0] mem_data;

    initial begin
        tbl[0] = '{32'h8000_0000, 0, 1'b0, 32'h0000_0413, 32'h0000_0413, 2'b00, 1'b1};
        tbl[1] = '{32'h8000_0004, 2, 1'b0, 32'h1234_5678, 32'h1234_5678, 2'b00, 1'b1};
        tbl[2] = '{32'h8000_0008, 3, 1'b0, 32'hCAFE_F00D, 32'hCAFE_F00D, 2'b00, 1'b1};
        tbl[3] = '{32'h8000_000C, 9, 1'b0, 32'h1111_1111, 32'h0000_0000, 2'b11, 1'b0};
        tbl[4] = '{32'h8000_0010, 1, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 2'b10, 1'b0};
        tbl[5] = '{32'h8000_0002, 0, 1'b0, 32'h0000_0000, 32'h0000_0000, 2'b01, 1'b0};
        tbl[6] = '{32'h8000_0021, 0, 1'b0, 32'h0000_0000, 32'h0000_0000, 2'b01, 1'b0};

        do_reset();
        for (int i = 0; i < 7; i++) fetch_one(tbl[i]);

        // Request back-pressure: valid/addr held while ready is low.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            flush = 1'b0; pc = 32'h8000_0100; req_ready = (i == 3);
            #1;
            chk("bp_req_valid", 32'(req_valid), 1);
            chk("bp_req_addr",  req_addr, 32'h8000_0100);
        end
        @(negedge clk);
        req_ready = 1'b0; rsp_valid = 1'b1; rsp_data = 32'hA5A5_0001; rsp_err = 1'b0;
        #1;
        chk("bp_wait_req_valid", 32'(req_valid), 0);
        @(negedge clk);
        rsp_valid = 1'b0; inst_ready = 1'b1;
        #1;
        chk("bp_inst", inst, 32'hA5A5_0001);
        chk("bp_pc_wen", 32'(pc_wen), 1);
        @(negedge clk);
        inst_ready = 1'b0; pc = 32'h8000_0104;
        #1;
        chk("bp_after_inst_valid", 32'(inst_valid), 0);

        // Flush in WAIT, then a late response absorbed by DRAIN.
        @(negedge clk);
        pc = 32'h8000_0200; req_ready = 1'b1;
        #1;
        chk("fl_req_valid", 32'(req_valid), 1);
        @(negedge clk);
        req_ready = 1'b0;
        #1;
        chk("fl_wait_inst_valid", 32'(inst_valid), 0);
        @(negedge clk);
        flush = 1'b1; pc = 32'h8000_0300;
        #1;
        chk("fl_flush_req_valid", 32'(req_valid), 0);
        chk("fl_flush_pc_wen",    32'(pc_wen), 0);
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("fl_drain0_req_valid", 32'(req_valid), 0);
        @(negedge clk);
        flush = 1'b1;
        #1;
        chk("fl_drain_flush_req_valid", 32'(req_valid), 0);
        @(negedge clk);
        flush = 1'b0; rsp_valid = 1'b1; rsp_data = 32'hDEAD_BEEF;
        #1;
        chk("fl_drain_rsp_req_valid",  32'(req_valid), 0);
        chk("fl_drain_rsp_inst_valid", 32'(inst_valid), 0);
        @(negedge clk);
        rsp_valid = 1'b0;
        #1;
        chk("fl_new_req_valid",  32'(req_valid), 1);
        chk("fl_new_req_addr",   req_addr, 32'h8000_0300);
        chk("fl_new_inst_valid", 32'(inst_valid), 0);
        chk("fl_new_pc_wen",     32'(pc_wen), 0);

        // HOLD stall with a stray response, then reset in the middle of WAIT.
        @(negedge clk);
        pc = 32'h8000_0400; req_ready = 1'b1;
        #1;
        chk("st_req_addr", req_addr, 32'h8000_0400);
        @(negedge clk);
        req_ready = 1'b0; rsp_valid = 1'b1; rsp_data = 32'h1357_9BDF; rsp_err = 1'b0;
        @(negedge clk);
        rsp_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            rsp_valid = (i == 2); rsp_data = (i == 2) ? 32'hDEAD_BEEF : 32'd0;
            #1;
            chk("st_inst_valid", 32'(inst_valid), 1);
            chk("st_inst",       inst, 32'h1357_9BDF);
            chk("st_inst_pc",    inst_pc, 32'h8000_0400);
            chk("st_pc_wen",     32'(pc_wen), 0);
        end
        @(negedge clk);
        rsp_valid = 1'b0; inst_ready = 1'b1;
        #1;
        chk("st_accept_pc_wen", 32'(pc_wen), 1);
        @(negedge clk);
        inst_ready = 1'b0; pc = 32'h8000_0404; req_ready = 1'b1;
        #1;
        chk("st_next_req_valid", 32'(req_valid), 1);
        @(negedge clk);
        req_ready = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        chk_zero("async_rst");
        do_reset();

        // Random traffic against the reference model
        m_pend = 0; m_drain = 0; m_show = 0; m_park = 0; m_cnt = 0; m_dcnt = 0;
        m_pc = 32'h8000_0000; m_acc = 0; x_inst = 0; x_ipc = 0; x_fault = 2'b00;
        mem_due = 0; mem_err = 0; mem_cnt = 0; mem_data = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic free, fl, rv, x_req, x_wen;
            int   d;
            @(negedge clk);
            free = !(m_pend | m_drain | m_show | m_park);
            fl = m_park ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 11) == 0);
            flush = fl; pc = m_pc;
            req_ready  = ($urandom_range(0, 2) != 0);
            inst_ready = 1'($urandom_range(0, 1));
            rsp_data = $urandom; rsp_err = 1'($urandom_range(0, 1)); rv = 1'b0;
            if (mem_due && mem_cnt == 0) begin
                rv = 1'b1; rsp_data = mem_data; rsp_err = mem_err;
            end else if (!m_pend && !m_drain && $urandom_range(0, 7) == 0) begin
                rv = 1'b1; rsp_data = 32'hDEAD_BEEF;
            end
            rsp_valid = rv;
            #1;
            x_req = free & ~fl & (m_pc[1:0] == 2'b00);
            x_wen = m_show & inst_ready & ~fl & (x_fault == 2'b00);
            chk("rnd_req_valid", 32'(req_valid), 32'(x_req));
            if (x_req) chk("rnd_req_addr", req_addr, m_pc);
            chk("rnd_inst_valid", 32'(inst_valid), 32'(m_show));
            if (m_show) begin
                chk("rnd_inst",    inst, x_inst);
                chk("rnd_inst_pc", inst_pc, x_ipc);
                chk("rnd_fault",   32'(inst_fault), 32'(x_fault));
            end
            chk("rnd_pc_wen", 32'(pc_wen), 32'(x_wen));

            if (mem_due) begin
                if (mem_cnt == 0) mem_due = 1'b0;
                else mem_cnt--;
            end
            if (free) begin
                if (!fl) begin
                    if (m_pc[1:0] != 2'b00) begin
                        m_show = 1; x_inst = 0; x_ipc = m_pc; x_fault = 2'b01;
                    end else if (req_ready) begin
                        m_pend = 1; m_cnt = 0; m_acc = m_pc;
                        d = int'($urandom_range(0, 5));
                        if (d < MW) begin
                            mem_due = 1; mem_cnt = d; mem_data = $urandom;
                            mem_err = ($urandom_range(0, 5) == 0);
                        end
                    end
                end
            end else if (m_pend) begin
                if (rv) begin
                    m_pend = 0;
                    if (!fl) begin
                        m_show = 1; x_ipc = m_acc;
                        x_inst  = rsp_err ? 32'd0 : rsp_data;
                        x_fault = rsp_err ? 2'b10 : 2'b00;
                    end
                end else if (fl) begin
                    m_pend = 0; m_drain = 1; m_dcnt = 0;
                end else if (m_cnt == MW - 1) begin
                    m_pend = 0; m_show = 1; x_inst = 0; x_ipc = m_acc; x_fault = 2'b11;
                end else begin
                    m_cnt++;
                end
            end else if (m_drain) begin
                if (rv || m_dcnt == MW - 1) m_drain = 0;
                else m_dcnt++;
            end else if (m_show) begin
                if (fl) begin
                    m_show = 0;
                end else if (inst_ready) begin
                    m_show = 0;
                    if (x_fault != 2'b00) m_park = 1;
                end
            end else if (m_park) begin
                if (fl) m_park = 0;
            end
            if (fl) begin
                m_pc = 32'h8000_0000 + ($urandom_range(0, 255) << 2);
                if ($urandom_range(0, 5) == 0) m_pc[1:0] = 2'($urandom_range(1, 3));
            end else if (x_wen) begin
                m_pc = m_pc + 32'd4;
                n_good++;
            end
        end
        n_checks++;
        if (n_good < 20) begin
            n_err++;
            $display("FAIL rnd_progress: got %0d accepted fetches required at least 20", n_good);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
